// File: rtl/sample_serializer.sv
// sample_serializer: paces a sample source with generate_next, captures the
// returned 16-bit sample and sends it MSB-first on a sclk/sdata/frame_sync link.
// If the source stays silent, the previous sample is sent again so the DAC
// stream keeps its cadence. Every serial output comes straight from a flop.
module sample_serializer #(
   parameter int unsigned SAMPLE_PERIOD = 256,
   parameter int unsigned BIT_DIV       = 4,
   parameter int unsigned TIMEOUT       = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic        generate_next,
   input  logic        sample_ready,
   input  logic [15:0] sample,
   output logic        sclk,
   output logic        sdata,
   output logic        frame_sync,
   output logic        timeout_err,
   output logic        overrun_err
);

   localparam int PER_W = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int TO_W  = $clog2(TIMEOUT + 1);
   localparam int DIV_W = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;

   localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
   localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BIT_DIV / 2);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQUEST = 2'd1,
      ST_WAIT    = 2'd2,
      ST_SHIFT   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [PER_W-1:0]  per_q, per_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic [TO_W-1:0]   to_inc;
   logic [DIV_W-1:0]  tmr_q, tmr_d;
   logic [3:0]        idx_q, idx_d;
   logic [15:0]       hold_q, hold_d;
   logic [15:0]       shift_q, shift_d;
   logic              terr_q, terr_d;
   logic              oerr_q, oerr_d;
   logic              gen_q, gen_d;
   logic              sclk_q, sclk_d;
   logic              sdata_q, sdata_d;
   logic              fs_q, fs_d;
   logic              tick;

   // Sample period timer: free-runs while enabled, held at zero otherwise.
   always_comb begin
      per_d = '0;
      tick  = 1'b0;
      if (enable) begin
         if (per_q == PER_LAST) begin
            per_d = '0;
            tick  = 1'b1;
         end else begin
            per_d = per_q + PER_W'(1);
            tick  = 1'b0;
         end
      end else begin
         per_d = '0;
         tick  = 1'b0;
      end
   end

   // Next-state logic for the request/wait/shift sequence and error flags.
   always_comb begin
      state_d = state_q;
      to_d    = to_q;
      tmr_d   = tmr_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      shift_d = shift_q;
      terr_d  = terr_q;
      oerr_d  = oerr_q;
      to_inc  = to_q + TO_W'(1);

      // A tick that finds the sequencer busy is lost; remember it.
      if (tick && (state_q != ST_IDLE)) begin
         oerr_d = 1'b1;
      end else begin
         oerr_d = oerr_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (tick) begin
               state_d = ST_REQUEST;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQUEST: begin
            state_d = ST_WAIT;
            to_d    = '0;
         end
         ST_WAIT: begin
            to_d = to_inc;
            if (sample_ready) begin
               hold_d  = sample;
               shift_d = sample;
               tmr_d   = '0;
               idx_d   = 4'd15;
               state_d = ST_SHIFT;
            end else if (to_inc == TO_LIMIT) begin
               // Source missed its slot: resend the last sample.
               terr_d  = 1'b1;
               shift_d = hold_q;
               tmr_d   = '0;
               idx_d   = 4'd15;
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_SHIFT: begin
            if (tmr_q == DIV_LAST) begin
               tmr_d = '0;
               if (idx_q == 4'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  idx_d = idx_q - 4'd1;
               end
            end else begin
               tmr_d = tmr_q + DIV_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output flop inputs, decoded from the next state so outputs line up with it.
   always_comb begin
      gen_d   = (state_d == ST_REQUEST);
      sclk_d  = 1'b0;
      sdata_d = 1'b0;
      fs_d    = 1'b0;
      if (state_d == ST_SHIFT) begin
         sclk_d  = (tmr_d >= DIV_HALF);
         sdata_d = shift_d[idx_d];
         fs_d    = (idx_d == 4'd15);
      end else begin
         sclk_d  = 1'b0;
         sdata_d = 1'b0;
         fs_d    = 1'b0;
      end
   end

   // State, datapath and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         per_q   <= '0;
         to_q    <= '0;
         tmr_q   <= '0;
         idx_q   <= 4'd0;
         hold_q  <= 16'h0000;
         shift_q <= 16'h0000;
         terr_q  <= 1'b0;
         oerr_q  <= 1'b0;
         gen_q   <= 1'b0;
         sclk_q  <= 1'b0;
         sdata_q <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         per_q   <= per_d;
         to_q    <= to_d;
         tmr_q   <= tmr_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         shift_q <= shift_d;
         terr_q  <= terr_d;
         oerr_q  <= oerr_d;
         gen_q   <= gen_d;
         sclk_q  <= sclk_d;
         sdata_q <= sdata_d;
         fs_q    <= fs_d;
      end
   end

   assign generate_next = gen_q;
   assign sclk          = sclk_q;
   assign sdata         = sdata_q;
   assign frame_sync    = fs_q;
   assign timeout_err   = terr_q;
   assign overrun_err   = oerr_q;

endmodule

// File: tb/tb_sample_serializer.sv
// Bench for sample_serializer: directed source responses, a queue of expected
// frame words, and a monitor that decodes the serial link on sclk rises.
module tb_sample_serializer;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable, sample_ready;
   logic [15:0] sample;
   logic        generate_next, sclk, sdata, frame_sync, timeout_err, overrun_err;
   logic        en2, ready2;
   logic [15:0] sample2;
   logic        gen2, sclk2, sdata2, fs2, terr2, oerr2;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          frames = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   // Cycle stamp used to measure intervals between requests.
   always @(posedge clk) cyc <= cyc + 1;

   sample_serializer dut (
      .clk(clk), .reset(reset), .enable(enable), .generate_next(generate_next),
      .sample_ready(sample_ready), .sample(sample), .sclk(sclk), .sdata(sdata),
      .frame_sync(frame_sync), .timeout_err(timeout_err), .overrun_err(overrun_err)
   );

   sample_serializer #(.SAMPLE_PERIOD(40), .BIT_DIV(4), .TIMEOUT(8)) dut2 (
      .clk(clk), .reset(reset), .enable(en2), .generate_next(gen2),
      .sample_ready(ready2), .sample(sample2), .sclk(sclk2), .sdata(sdata2),
      .frame_sync(fs2), .timeout_err(terr2), .overrun_err(oerr2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for a request pulse; n = cycles waited.
   task automatic wait_gen(input bit which, input int limit, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (((which ? gen2 : generate_next) !== 1'b1) && (n < limit));
      chk(which ? "gen2_seen" : "gen_seen", {31'd0, (which ? gen2 : generate_next)}, 32'd1);
   endtask

   // Two-cycle source: sample_ready lands on the 2nd WAIT cycle.
   task automatic respond(input bit which, input logic [15:0] v);
      if (!which) exp_q.push_back(v);
      step();
      chk("gen_pulse_width", {31'd0, (which ? gen2 : generate_next)}, 32'd0);
      step();
      if (which) begin
         ready2 = 1'b1; sample2 = v;
      end else begin
         sample_ready = 1'b1; sample = v;
      end
      step();
      ready2 = 1'b0; sample2 = 16'h0000;
      sample_ready = 1'b0; sample = 16'h0000;
   endtask

   initial begin
      int n;
      int t1;
      int nz;
      logic [5:0] outs;
      reset = 1'b1; enable = 1'b0; sample_ready = 1'b0; sample = 16'h0000;
      en2 = 1'b0; ready2 = 1'b0; sample2 = 16'h0000;

      fork
         // Monitor: rebuilds each frame from sclk rises and pops the scoreboard.
         begin
            logic        prev_sclk;
            logic        in_frame;
            int          bitcnt;
            int          fs_cnt;
            logic [15:0] word;
            logic [15:0] e;
            prev_sclk = 1'b0; in_frame = 1'b0; bitcnt = 0; fs_cnt = 0; word = 16'h0000;
            forever begin
               @(negedge clk);
               if (reset) begin
                  if (in_frame && exp_q.size() > 0) e = exp_q.pop_front();
                  in_frame = 1'b0; prev_sclk = 1'b0; fs_cnt = 0; bitcnt = 0;
               end else begin
                  if (frame_sync) begin
                     fs_cnt++;
                  end else if (fs_cnt > 0) begin
                     chk("frame_sync_width", fs_cnt, 32'd4);
                     fs_cnt = 0;
                  end
                  if (sclk && !prev_sclk) begin
                     if (frame_sync) begin
                        if (in_frame) begin
                           chk("short_frame_bits", bitcnt, 32'd16);
                           if (exp_q.size() > 0) e = exp_q.pop_front();
                        end
                        in_frame = 1'b1; bitcnt = 0; word = 16'h0000;
                     end
                     if (in_frame) begin
                        word = {word[14:0], sdata};
                        bitcnt++;
                        if (bitcnt == 16) begin
                           chk("queue_has_expected", {31'd0, (exp_q.size() > 0)}, 32'd1);
                           if (exp_q.size() > 0) begin
                              e = exp_q.pop_front();
                              chk("frame_data", {16'd0, word}, {16'd0, e});
                           end
                           frames++;
                           in_frame = 1'b0;
                        end
                     end else begin
                        chk("extra_sclk_rise", 32'd1, 32'd0);
                     end
                  end
                  prev_sclk = sclk;
               end
            end
         end
         // Stimulus sequence.
         begin
            repeat (3) step();
            outs = {generate_next, sclk, sdata, frame_sync, timeout_err, overrun_err};
            chk("reset_outs", {26'd0, outs}, 32'd0);
            outs = {gen2, sclk2, sdata2, fs2, terr2, oerr2};
            chk("reset_outs2", {26'd0, outs}, 32'd0);
            reset = 1'b0;
            nz = 0;
            repeat (500) begin
               step();
               if ({generate_next, sclk, sdata, frame_sync, timeout_err, overrun_err} !== 6'd0) nz++;
            end
            chk("idle_quiet", nz, 32'd0);

            // Normal frames.
            enable = 1'b1;
            wait_gen(1'b0, 600, n);
            chk("first_gen_delay", n, 32'd256);
            t1 = cyc;
            respond(1'b0, 16'hA5C3);
            step();
            chk("sclk_lat_low", {31'd0, sclk}, 32'd0);
            step();
            chk("sclk_lat_rise", {31'd0, sclk}, 32'd1);

            wait_gen(1'b0, 600, n);
            chk("period1", cyc - t1, 32'd256);
            t1 = cyc;
            respond(1'b0, 16'hA5C3);
            repeat (10) step();
            sample_ready = 1'b1; sample = 16'hFFFF;      // stray ready in SHIFT
            step();
            sample_ready = 1'b0; sample = 16'h0000;
            repeat (100) step();
            sample_ready = 1'b1; sample = 16'hFFFF;      // stray ready in IDLE
            step();
            sample_ready = 1'b0; sample = 16'h0000;
            chk("no_timeout_err", {31'd0, timeout_err}, 32'd0);
            chk("no_overrun_err", {31'd0, overrun_err}, 32'd0);

            // Source goes silent: previous sample must be resent.
            wait_gen(1'b0, 600, n);
            chk("period2", cyc - t1, 32'd256);
            t1 = cyc;
            exp_q.push_back(16'hA5C3);
            repeat (8) step();
            chk("terr_before_limit", {31'd0, timeout_err}, 32'd0);
            step();
            chk("terr_set", {31'd0, timeout_err}, 32'd1);

            wait_gen(1'b0, 600, n);
            chk("period3", cyc - t1, 32'd256);
            respond(1'b0, 16'h8001);
            chk("terr_sticky", {31'd0, timeout_err}, 32'd1);
            repeat (80) step();
            chk("frames_4", frames, 32'd4);
            chk("queue_empty_4", exp_q.size(), 32'd0);

            // Asynchronous reset inside bit 9 of a frame.
            wait_gen(1'b0, 600, n);
            respond(1'b0, 16'h5A3C);
            repeat (26) step();
            chk("pre_rst_sclk", {31'd0, sclk}, 32'd1);
            chk("pre_rst_sdata_b9", {31'd0, sdata}, 32'd1);
            chk("pre_rst_fs", {31'd0, frame_sync}, 32'd0);
            chk("pre_rst_terr", {31'd0, timeout_err}, 32'd1);
            #2 reset = 1'b1;
            #1;
            outs = {generate_next, sclk, sdata, frame_sync, timeout_err, overrun_err};
            chk("async_rst_outs", {26'd0, outs}, 32'd0);
            repeat (3) step();
            reset = 1'b0;
            wait_gen(1'b0, 600, n);
            chk("post_rst_gen_delay", n, 32'd256);
            respond(1'b0, 16'h0F0F);
            chk("post_rst_terr", {31'd0, timeout_err}, 32'd0);
            repeat (80) step();
            chk("frames_5", frames, 32'd5);
            chk("queue_empty_5", exp_q.size(), 32'd0);
            enable = 1'b0;

            // Overrun: 40-cycle period against a 67-cycle sequence.
            en2 = 1'b1;
            wait_gen(1'b1, 200, n);
            chk("ovr_first_gen", n, 32'd40);
            respond(1'b1, 16'h1234);
            repeat (36) step();
            chk("ovr_before_tick", {31'd0, oerr2}, 32'd0);
            step();
            chk("ovr_set", {31'd0, oerr2}, 32'd1);
            chk("ovr_gen_skipped", {31'd0, gen2}, 32'd0);
            wait_gen(1'b1, 200, n);
            chk("ovr_next_gen", n, 32'd40);
            chk("ovr_sticky", {31'd0, oerr2}, 32'd1);
            chk("ovr_no_terr", {31'd0, terr2}, 32'd0);
            en2 = 1'b0;
         end
      join_any
      disable fork;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sample_serializer.md
Name: sample_serializer

Overview:
Consumer-side partner of the sine sample source. Paces the sample stream by pulsing generate_next once per sample period, then captures the returned 16-bit sample on sample_ready. It serialises each sample MSB-first onto a simple serial DAC link (sclk/sdata/frame_sync). It sits between the sample generator and the board-level DAC pins.

Parameters:
SAMPLE_PERIOD, 256, clk cycles between sample requests; must exceed TIMEOUT + 2 + 16*BIT_DIV.
BIT_DIV, 4, clk cycles per serial bit; even, >= 2.
TIMEOUT, 8, WAIT-state cycles allowed before a sample_ready is declared missing.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  level; 1 = run the sample period timer.
generate_next  output  1  one-cycle request pulse to the sample source.
sample_ready  input  1  one-cycle pulse from the source: sample is valid.
sample  input  16  two's-complement sample; valid only while sample_ready = 1.
sclk  output  1  serial bit clock.
sdata  output  1  serial data, MSB first; changes on sclk falling edge.
frame_sync  output  1  high for the whole MSB bit period.
timeout_err  output  1  sticky: a request got no sample_ready within TIMEOUT.
overrun_err  output  1  sticky: a period tick arrived while not IDLE.

Behaviour:
- Reset (async, any time, including mid-frame): state IDLE; period counter, timeout counter, bit timer and bit index = 0; holding and shift registers = 0. Outputs generate_next, sclk, sdata, frame_sync, timeout_err and overrun_err = 0. The sticky flags clear only on reset.
- Period counter: while enable = 1 it counts 0..SAMPLE_PERIOD-1 and wraps to 0. A tick is asserted on the cycle it equals SAMPLE_PERIOD-1. While enable = 0 it is held at 0 and produces no tick. The first tick occurs SAMPLE_PERIOD cycles after enable rises.
- FSM states: IDLE, REQUEST, WAIT, SHIFT.
- IDLE: on tick, go to REQUEST. A tick in any other state is dropped and sets overrun_err.
- REQUEST: lasts one cycle with generate_next = 1, then goes to WAIT with the timeout counter cleared. generate_next is 0 in every other state.
- WAIT: the timeout counter increments each cycle.
  - If sample_ready = 1, latch sample into the holding register and go to SHIFT.
  - Otherwise, when the counter reaches TIMEOUT, set timeout_err and go to SHIFT with the holding register unchanged, so the previous sample is re-sent and the stream stays continuous.
  - With a 2-cycle source, sample_ready arrives on the 2nd WAIT cycle.
- sample_ready is ignored outside WAIT. The holding register changes only in WAIT.
- SHIFT, on entry: shift register <= holding register (or the captured sample, same cycle), bit index = 15, bit timer = 0.
  - The bit timer counts 0..BIT_DIV-1.
  - sclk = 0 while bit timer < BIT_DIV/2, else 1.
  - sdata = shift register[bit index]. It updates only when the bit timer wraps, i.e. on the sclk falling edge; the receiver samples on sclk rising.
  - frame_sync = 1 while bit index = 15.
  - After bit 0 completes (16*BIT_DIV cycles in SHIFT), go to IDLE.
- Outside SHIFT: sclk = 0, sdata = 0, frame_sync = 0. All serial outputs are registered, with no combinational path from inputs.
- enable deasserted mid-frame: the current REQUEST/WAIT/SHIFT sequence completes normally, then the FSM stays in IDLE. enable does not affect the FSM except through tick.
- End-to-end latency: tick to generate_next = 1 cycle. generate_next to first sclk rise = 2 + BIT_DIV/2 + 1 cycles with a 2-cycle source.

Test Plan:
- Reset: hold reset 3 cycles, then release with enable = 0 for 500 cycles -> all outputs stay 0 and generate_next never pulses.
- Normal frame (defaults): enable = 1, source model returns 16'hA5C3 two cycles after generate_next -> generate_next pulses at cycles 257, 513, ... and frame_sync is high for 4 cycles. Bits captured on sclk rising are 1010_0101_1100_0011, 16 sclk rises per frame, and both error flags stay 0.
- Timeout: after one 16'hA5C3 frame, the source stops answering -> 8 WAIT cycles elapse, timeout_err = 1 and stays 1, and the next frame re-sends 1010_0101_1100_0011.
- Overrun: SAMPLE_PERIOD = 40, BIT_DIV = 4 (frame takes 64+ cycles) -> overrun_err = 1 at the second tick and generate_next is skipped for that period.
- Stray ready: pulse sample_ready with sample = 16'hFFFF while IDLE and while SHIFT -> ignored, and the serialised data still equals the last captured sample.
- Async reset mid-SHIFT (bit index 9): assert reset between clock edges -> sclk, sdata, frame_sync and the flags go to 0 immediately. After release, the next frame starts only after a full SAMPLE_PERIOD.
